// File: rtl/frame_fetch.sv
// frame_fetch: reads one IMG_W x IMG_H frame from a synchronous memory and streams it
// over valid/ready, tagging each word with start-of-line, end-of-line and end-of-frame.
module frame_fetch #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 7,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_eof
);
    localparam int N     = IMG_W * IMG_H;
    localparam int IDX_W = $clog2(N + 1);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if (N > (1 << ADDR_W)) begin : g_size_check
        $error("frame_fetch: IMG_W*IMG_H exceeds the memory address space");
    end

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              inflight_q, inflight_d;
    logic [2:0]        infl_flags_q, infl_flags_d;   // {sol, eol, eof}
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic [2:0]        fifo_flags_q [2];
    logic [2:0]        fifo_flags_d [2];

    logic              issue;
    logic              pop;
    logic [2:0]        rd_flags;
    logic [2:0]        head_flags;

    // The word returning from memory acts as the FIFO head when the FIFO is empty, so
    // a full-rate stream never has to land in the buffer before it is handed off.
    always_comb begin
        rd_flags   = '0;
        pix_data   = '0;
        head_flags = '0;
        rd_flags[2] = (col_q == '0);
        rd_flags[1] = (col_q == COL_W'(IMG_W - 1));
        rd_flags[0] = rd_flags[1] && (row_q == ROW_W'(IMG_H - 1));
        issue     = (state_q == S_FETCH) && ((count_q + {1'b0, inflight_q}) < 2'd2);
        pix_valid = (count_q != 2'd0) || inflight_q;
        if (count_q != 2'd0) begin
            pix_data   = fifo_data_q[0];
            head_flags = fifo_flags_q[0];
        end else if (inflight_q) begin
            pix_data   = mem_rd_data;
            head_flags = infl_flags_q;
        end
        pop = pix_valid && pix_ready;

        fifo_data_d  = fifo_data_q;
        fifo_flags_d = fifo_flags_q;
        count_d      = count_q;
        if (pop && count_q != 2'd0) begin
            fifo_data_d[0]  = fifo_data_q[1];
            fifo_flags_d[0] = fifo_flags_q[1];
            count_d         = count_q - 2'd1;
        end
        if (inflight_q && !(pop && count_q == 2'd0)) begin
            fifo_data_d[count_d[0]]  = mem_rd_data;
            fifo_flags_d[count_d[0]] = infl_flags_q;
            count_d                  = count_d + 2'd1;
        end
        inflight_d   = issue;
        infl_flags_d = rd_flags;
    end

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        col_d    = col_q;
        row_d    = row_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (issue && rd_flags[0]) state_d = S_DRAIN;
            S_DRAIN: if (pop && head_flags[0]) state_d = S_DONE;
            S_DONE: begin
                state_d  = S_IDLE;
                rd_idx_d = '0;
                col_d    = '0;
                row_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rd_idx_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            inflight_q   <= 1'b0;
            infl_flags_q <= '0;
            count_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_flags_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rd_idx_q     <= rd_idx_d;
            col_q        <= col_d;
            row_q        <= row_d;
            inflight_q   <= inflight_d;
            infl_flags_q <= infl_flags_d;
            count_q      <= count_d;
            fifo_data_q  <= fifo_data_d;
            fifo_flags_q <= fifo_flags_d;
        end
    end

    assign mem_rd_en = issue;
    assign mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx_q);
    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pix_sol   = head_flags[2];
    assign pix_eol   = head_flags[1];
    assign pix_eof   = head_flags[0];
endmodule

// File: tb/tb_frame_fetch.sv
// Bench for frame_fetch: three instances (8x4 at base 0, 8x4 at base 120, 1x1) driven with
// random ready patterns and checked against a word-index reference model.
module tb_frame_fetch;
    localparam int NU = 3;

    function automatic int bav(input int u);
        return (u == 1) ? 120 : 0;
    endfunction
    function automatic int wv(input int u);
        return (u == 2) ? 1 : 8;
    endfunction
    function automatic int hv(input int u);
        return (u == 2) ? 1 : 4;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start [NU];
    logic        busy [NU];
    logic        done [NU];
    logic        mem_rd_en [NU];
    logic [6:0]  mem_addr [NU];
    logic [31:0] mem_rd_data [NU];
    logic        pix_valid [NU];
    logic        pix_ready [NU];
    logic [31:0] pix_data [NU];
    logic        pix_sol [NU];
    logic        pix_eol [NU];
    logic        pix_eof [NU];
    logic [31:0] mem [NU][128];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rmode [NU];
    int st_cyc [NU];
    // reference-model state, owned by the monitor
    int k [NU];
    int issued [NU];
    int done_cnt [NU];
    int first_cyc [NU];
    int last_cyc [NU];
    int done_cyc [NU];
    logic busy_e [NU];
    logic done_e [NU];
    logic stall_prev [NU];
    logic [31:0] data_prev [NU];
    logic [2:0]  flags_prev [NU];

    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
        frame_fetch #(
            .DATA_W(32), .ADDR_W(7), .IMG_W(wv(gi)), .IMG_H(hv(gi)), .BASE_ADDR(bav(gi))
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[gi]), .busy(busy[gi]), .done(done[gi]),
            .mem_rd_en(mem_rd_en[gi]), .mem_addr(mem_addr[gi]), .mem_rd_data(mem_rd_data[gi]),
            .pix_valid(pix_valid[gi]), .pix_ready(pix_ready[gi]), .pix_data(pix_data[gi]),
            .pix_sol(pix_sol[gi]), .pix_eol(pix_eol[gi]), .pix_eof(pix_eof[gi])
        );
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NU; i++)
            if (mem_rd_en[i]) mem_rd_data[i] <= mem[i][mem_addr[i]];
    end

    initial begin
        for (int i = 0; i < NU; i++) pix_ready[i] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NU; i++) begin
                case (rmode[i])
                    0: pix_ready[i] = 1'b1;
                    1: pix_ready[i] = ~pix_ready[i];
                    2: pix_ready[i] = 1'($urandom_range(0, 1));
                    default: pix_ready[i] = (k[i] < 13);
                endcase
            end
        end
    end

    // Reference model: word k of a frame is mem[(base+k) mod 128]; flags follow from k.
    always @(negedge clk) begin
        logic xfer, lastw, done_n;
        int n, w;
        for (int i = 0; i < NU; i++) begin
            n = wv(i) * hv(i);
            w = wv(i);
            if (!rst_n) begin
                chk($sformatf("u%0d.rst_ctrl", i), {busy[i], done[i], mem_rd_en[i], pix_valid[i]}, 0);
                chk($sformatf("u%0d.rst_pix", i), {pix_data[i], pix_sol[i], pix_eol[i], pix_eof[i]}, 0);
                chk($sformatf("u%0d.rst_addr", i), mem_addr[i], bav(i) % 128);
                k[i] = 0; issued[i] = 0; busy_e[i] = 0; done_e[i] = 0; stall_prev[i] = 0;
            end else begin
                xfer  = pix_valid[i] && pix_ready[i];
                lastw = xfer && (k[i] == n - 1);
                chk($sformatf("u%0d.busy", i), busy[i], busy_e[i]);
                chk($sformatf("u%0d.done", i), done[i], done_e[i]);
                if (done[i]) begin
                    chk($sformatf("u%0d.words", i), k[i], n);
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                if (!busy_e[i])
                    chk($sformatf("u%0d.idle_quiet", i), {pix_valid[i], mem_rd_en[i]}, 0);
                if (mem_rd_en[i]) begin
                    chk($sformatf("u%0d.occupancy", i), (issued[i] - k[i]) < 2, 1);
                    chk($sformatf("u%0d.addr", i), mem_addr[i], (bav(i) + issued[i]) % 128);
                    chk($sformatf("u%0d.overread", i), issued[i] < n, 1);
                    issued[i]++;
                end
                if (stall_prev[i])
                    chk($sformatf("u%0d.hold", i),
                        {pix_valid[i], pix_data[i], pix_sol[i], pix_eol[i], pix_eof[i]},
                        {1'b1, data_prev[i], flags_prev[i]});
                if (xfer) begin
                    chk($sformatf("u%0d.data[%0d]", i, k[i]), pix_data[i], mem[i][(bav(i) + k[i]) % 128]);
                    chk($sformatf("u%0d.flags[%0d]", i, k[i]), {pix_sol[i], pix_eol[i], pix_eof[i]},
                        {(k[i] % w) == 0, (k[i] % w) == w - 1, k[i] == n - 1});
                    if (k[i] == 0) first_cyc[i] = cyc;
                    last_cyc[i] = cyc;
                    k[i]++;
                end
                stall_prev[i] = pix_valid[i] && !pix_ready[i];
                data_prev[i]  = pix_data[i];
                flags_prev[i] = {pix_sol[i], pix_eol[i], pix_eof[i]};
                done_n = lastw;
                if (busy_e[i]) begin
                    busy_e[i] = !lastw;
                end else if (!done_e[i] && start[i]) begin
                    busy_e[i] = 1'b1;
                    k[i] = 0;
                    issued[i] = 0;
                end
                done_e[i] = done_n;
            end
        end
    end

    task automatic run_frame(input int u, input bit extra_start);
        int d0;
        d0 = done_cnt[u];
        @(posedge clk); #1;
        start[u] = 1'b1;
        st_cyc[u] = cyc;
        @(posedge clk); #1;
        start[u] = 1'b0;
        for (int i = 0; i < 2000 && done_cnt[u] == d0; i++) begin
            @(posedge clk); #1;
            start[u] = extra_start && (i < 20) && (i % 7 == 3);
        end
        start[u] = 1'b0;
        chk($sformatf("u%0d.frame_done", u), done_cnt[u] - d0, 1);
        repeat (10) @(posedge clk);
        #1;
        chk($sformatf("u%0d.one_done", u), done_cnt[u] - d0, 1);
        chk($sformatf("u%0d.back_idle", u), {busy[u], pix_valid[u]}, 0);
    endtask

    initial begin
        for (int i = 0; i < NU; i++) begin
            start[i] = 1'b0;
            rmode[i] = 0;
            for (int a = 0; a < 128; a++)
                mem[i][a] = (i == 0) ? 32'(a + 1) : $urandom;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame(0, 1'b0);
        chk("u0.latency", first_cyc[0] - st_cyc[0], 2);
        chk("u0.burst_span", last_cyc[0] - first_cyc[0], 31);
        chk("u0.done_after_eof", done_cyc[0] - last_cyc[0], 1);

        rmode[0] = 1;
        run_frame(0, 1'b0);
        rmode[0] = 2;
        run_frame(0, 1'b0);
        run_frame(0, 1'b0);
        rmode[0] = 0;
        run_frame(0, 1'b1);

        rmode[1] = 2;
        run_frame(1, 1'b0);
        rmode[1] = 0;
        run_frame(1, 1'b0);

        run_frame(2, 1'b0);
        rmode[2] = 2;
        run_frame(2, 1'b0);

        // abort mid-frame while word 13 is stalled at the head
        rmode[0] = 3;
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int i = 0; i < 200 && k[0] < 13; i++) begin
            @(posedge clk); #1;
        end
        chk("u0.reached_word13", k[0], 13);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("u0.abort_ctrl", {busy[0], done[0], mem_rd_en[0], pix_valid[0]}, 0);
        chk("u0.abort_pix", {pix_data[0], pix_sol[0], pix_eol[0], pix_eof[0]}, 0);
        chk("u0.abort_addr", mem_addr[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rmode[0] = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("u0.no_valid_after_abort", pix_valid[0], 0);
        run_frame(0, 1'b0);
        chk("u0.restart_latency", first_cyc[0] - st_cyc[0], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
